// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between the operand source, alu_seq and the result consumer.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [4:0]       flags;
    logic [4:0]       sticky;
    logic             clr_sticky;

    modport slave (
        input  in_valid, a, b, op, out_ready, clr_sticky,
        output in_ready, out_valid, y, flags, sticky
    );

    modport master (
        output in_valid, a, b, op, out_ready, clr_sticky,
        input  in_ready, out_valid, y, flags, sticky
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops load the output register on accept, MUL runs an
// iterative shift-add for WIDTH cycles first. Flags are {C, V, Z, N, P}.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SAR = 4'd8;
    localparam logic [3:0] OP_ROL = 4'd9;
    localparam logic [3:0] OP_ADC = 4'd10;
    localparam logic [3:0] OP_SBB = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;
    localparam logic [3:0] OP_CMP = 4'd13;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    typedef struct packed {
        logic [4:0]       flags;
        logic [WIDTH-1:0] y;
    } res_t;

    function automatic logic [4:0] flags_of(input logic c, input logic v,
                                            input logic [WIDTH-1:0] r);
        return {c, v, ~|r, r[WIDTH-1], ^r};
    endfunction

    function automatic res_t alu_eval(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b, input logic cin);
        logic [WIDTH:0]   ext;
        logic [SHW-1:0]   amt;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        res_t             res;
        ext = '0;
        amt = b[SHW-1:0];
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) && cin};
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            // The extra top bit of the difference is the borrow, cq included for SBB
            OP_SUB, OP_SBB, OP_CMP: begin
                ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBB) && cin};
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            // Shifts carry one guard bit so the last bit shifted out lands in C (0 for amt 0)
            OP_SHL: begin
                ext = {1'b0, a} << amt;
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
            end
            OP_SHR: begin
                ext = {a, 1'b0} >> amt;
                r   = ext[WIDTH:1];
                c   = ext[0];
            end
            OP_SAR: begin
                ext = $signed({a, 1'b0}) >>> amt;
                r   = ext[WIDTH:1];
                c   = ext[0];
            end
            OP_ROL: begin
                r = (a << amt) | (a >> (WIDTH - int'(amt)));
                c = r[0];
            end
            default: r = '0;
        endcase
        res.flags = flags_of(c, v, r);
        res.y     = (op == OP_CMP) ? a : r;
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [4:0]         flags_q, flags_d;
    logic [4:0]         sticky_q, sticky_d;
    logic               cq_q, cq_d;
    logic               in_ready;
    logic               accept;
    logic               load;
    res_t               alu_res;
    res_t               new_res;

    assign in_ready  = !rst && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign alu_res   = alu_eval(bus.op, bus.a, bus.b, cq_q);
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    // Issue / multiply sequencing
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        new_res  = alu_res;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, bus.a};
                        mplier_d = bus.b;
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            S_MUL: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    load          = 1'b1;
                    new_res.y     = prod_step[WIDTH-1:0];
                    new_res.flags = flags_of(|prod_step[2*WIDTH-1:WIDTH], 1'b0,
                                             prod_step[WIDTH-1:0]);
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output register, carry and sticky accumulation
    always_comb begin
        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        y_d      = load ? new_res.y     : y_q;
        flags_d  = load ? new_res.flags : flags_q;
        cq_d     = load ? new_res.flags[4] : cq_q;
        sticky_d = sticky_q;
        if (load) begin
            sticky_d = bus.clr_sticky ? new_res.flags : (sticky_q | new_res.flags);
        end else if (bus.clr_sticky) begin
            sticky_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            flags_q     <= '0;
            sticky_q    <= '0;
            cq_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
            sticky_q    <= sticky_d;
            cq_q        <= cq_d;
        end
    end

    // Multiplier working registers need no reset: they are reloaded on every MUL accept
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        prod_q   <= prod_d;
        cnt_q    <= cnt_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.flags     = flags_q;
    assign bus.sticky    = sticky_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomised checks of alu_seq against an integer-arithmetic reference model
// with an in-order expected-result queue.
module tb_alu_seq;
    localparam int W      = 8;
    localparam int MASK   = (1 << W) - 1;
    localparam int OP_MUL = 12;

    typedef struct {
        logic [W-1:0] y;
        logic [4:0]   fl;
        logic [4:0]   st;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t       q[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic       m_cq;
    logic [4:0] m_st;
    bit         last_acc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: results from plain integer arithmetic on the operand values
    function automatic void model(input int op, input int a, input int b, input logic cin,
                                  output logic [W-1:0] y, output logic [4:0] fl);
        int r, c, v, n, sa, sb, sr, yv, ci;
        n  = b % W;
        ci = cin ? 1 : 0;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        c  = 0;
        v  = 0;
        yv = 0;
        case (op)
            0, 10: begin
                if (op == 0) ci = 0;
                r  = a + b + ci;
                yv = r & MASK;
                c  = (r > MASK) ? 1 : 0;
                sr = sa + sb + ci;
                v  = (sr > (1 << (W - 1)) - 1 || sr < -(1 << (W - 1))) ? 1 : 0;
            end
            1, 11, 13: begin
                if (op != 11) ci = 0;
                r  = a - b - ci;
                yv = r & MASK;
                c  = (r < 0) ? 1 : 0;
                sr = sa - sb - ci;
                v  = (sr > (1 << (W - 1)) - 1 || sr < -(1 << (W - 1))) ? 1 : 0;
            end
            2: yv = a & b;
            3: yv = a | b;
            4: yv = a ^ b;
            5: yv = (~a) & MASK;
            6: begin
                yv = (a << n) & MASK;
                c  = (n > 0) ? ((a >> (W - n)) & 1) : 0;
            end
            7: begin
                yv = a >> n;
                c  = (n > 0) ? ((a >> (n - 1)) & 1) : 0;
            end
            8: begin
                yv = (sa >>> n) & MASK;
                c  = (n > 0) ? ((a >> (n - 1)) & 1) : 0;
            end
            9: begin
                yv = ((a << n) | (a >> (W - n))) & MASK;
                c  = yv & 1;
            end
            12: begin
                r  = a * b;
                yv = r & MASK;
                c  = ((r >> W) != 0) ? 1 : 0;
            end
            default: yv = 0;
        endcase
        fl = {c != 0, v != 0, yv == 0, ((yv >> (W - 1)) & 1) != 0, ($countones(yv) % 2) != 0};
        y  = (op == 13) ? a[W-1:0] : yv[W-1:0];
    endfunction

    // One clock: drive at the falling edge, check, update the model, advance.
    task automatic step(input bit iv, input int op, input int a, input int b,
                        input bit ordy, input bit clr);
        bit           acc, pop, exp_ov, exp_rdy;
        logic [W-1:0] ey;
        logic [4:0]   ef;
        exp_t         e;
        bus.in_valid   = iv;
        bus.op         = op[3:0];
        bus.a          = a[W-1:0];
        bus.b          = b[W-1:0];
        bus.out_ready  = ordy;
        bus.clr_sticky = clr;
        #1;
        exp_ov  = (q.size() > 0) && (cyc >= q[0].due);
        exp_rdy = (q.size() == 0) || (exp_ov && ordy);
        check_eq("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        check_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        acc = iv && (bus.in_ready === 1'b1);
        pop = (bus.out_valid === 1'b1) && ordy;
        last_acc = acc;
        if (pop && q.size() > 0) begin
            check_eq("y", 32'(bus.y), 32'(q[0].y));
            check_eq("flags", 32'(bus.flags), 32'(q[0].fl));
            check_eq("sticky", 32'(bus.sticky), 32'(q[0].st));
            void'(q.pop_front());
        end
        if (acc) begin
            model(op, a & MASK, b & MASK, m_cq, ey, ef);
            m_cq  = ef[4];
            m_st  = clr ? ef : (m_st | ef);
            e.y   = ey;
            e.fl  = ef;
            e.st  = m_st;
            e.due = cyc + 1 + ((op == OP_MUL) ? W : 0);
            q.push_back(e);
        end else if (clr) begin
            if (q.size() == 0) begin
                m_st = '0;
            end else if (cyc >= q[0].due) begin
                m_st     = '0;
                q[0].st  = '0;
            end else begin
                m_st     = q[0].fl;
                q[0].st  = q[0].fl;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic kat(input string tag, input int op, input int a, input int b,
                       input int ey, input int ef);
        step(1'b1, op, a, b, 1'b1, 1'b0);
        check_eq({tag, "_acc"}, 32'(last_acc), 32'd1);
        repeat ((op == OP_MUL) ? W : 0) step(1'b0, 0, 0, 0, 1'b1, 1'b0);
        check_eq({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        check_eq({tag, "_y"}, 32'(bus.y), ey);
        check_eq({tag, "_fl"}, 32'(bus.flags), ef);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.op         = 4'd0;
        bus.a          = 8'h11;
        bus.b          = 8'h22;
        bus.out_ready  = 1'b1;
        bus.clr_sticky = 1'b0;
        repeat (2) begin
            #1;
            check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_y", 32'(bus.y), 32'd0);
        check_eq("rst_flags", 32'(bus.flags), 32'd0);
        check_eq("rst_sticky", 32'(bus.sticky), 32'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        m_cq = 1'b0;
        m_st = '0;
    endtask

    function automatic int pick();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return MASK;
            2: return MASK >> 1;
            3: return 1 << (W - 1);
            default: return int'($urandom_range(0, MASK));
        endcase
    endfunction

    initial begin
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.op         = '0;
        bus.out_ready  = 1'b0;
        bus.clr_sticky = 1'b0;
        m_cq           = 1'b0;
        m_st           = '0;
        @(negedge clk);
        do_reset();

        kat("add_c8_64", 0, 8'hC8, 8'h64, 8'h2C, 5'h11);
        kat("sub_03_05", 1, 8'h03, 8'h05, 8'hFE, 5'h13);
        kat("add_7f_01", 0, 8'h7F, 8'h01, 8'h80, 5'h0B);
        kat("mul_0f_11", 12, 8'h0F, 8'h11, 8'hFF, 5'h02);
        kat("mul_10_10", 12, 8'h10, 8'h10, 8'h00, 5'h14);
        kat("sar_90_2", 8, 8'h90, 8'h02, 8'hE4, 5'h02);
        kat("shl_81_1", 6, 8'h81, 8'h01, 8'h02, 5'h11);
        kat("rol_81_1", 9, 8'h81, 8'h01, 8'h03, 5'h10);
        kat("shr_by0", 7, 8'hA5, 8'h08, 8'hA5, 5'h02);

        // Carry chain and sticky accumulation
        step(1'b0, 0, 0, 0, 1'b1, 1'b1);
        kat("chain_add", 0, 8'hFF, 8'h01, 8'h00, 5'h14);
        kat("chain_adc", 10, 8'h00, 8'h00, 8'h01, 5'h01);
        check_eq("sticky_chain", 32'(bus.sticky), 32'h15);
        step(1'b0, 0, 0, 0, 1'b1, 1'b1);
        check_eq("sticky_clr", 32'(bus.sticky), 32'h00);
        step(1'b1, 0, 8'h7F, 8'h01, 1'b1, 1'b1);
        check_eq("sticky_clr_ld", 32'(bus.sticky), 32'h0B);

        // Backpressure: result held, new request accepted in the pop cycle
        step(1'b0, 0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 2, 8'hF3, 8'h8F, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_y", 32'(bus.y), 32'h83);
            check_eq("bp_fl", 32'(bus.flags), 32'h03);
            step(1'b1, 0, 8'h01, 8'h02, 1'b0, 1'b0);
            check_eq("bp_no_acc", 32'(last_acc), 32'd0);
        end
        step(1'b1, 0, 8'h01, 8'h02, 1'b1, 1'b0);
        check_eq("bp_pop_acc", 32'(last_acc), 32'd1);
        check_eq("bp_new_vld", 32'(bus.out_valid), 32'd1);
        check_eq("bp_new_y", 32'(bus.y), 32'h03);

        // Reset in the middle of a multiply
        kat("pre_rst_add", 0, 8'hFF, 8'h01, 8'h00, 5'h14);
        step(1'b1, OP_MUL, 8'h33, 8'h55, 1'b1, 1'b0);
        repeat (3) step(1'b0, 0, 0, 0, 1'b1, 1'b0);
        do_reset();
        repeat (W + 2) step(1'b0, 0, 0, 0, 1'b1, 1'b0);
        kat("adc_after_rst", 10, 8'h05, 8'h03, 8'h08, 5'h01);

        // Randomised traffic with random backpressure and sticky clears
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 15)), pick(), pick(),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
        end
        repeat (W + 2) step(1'b0, 0, 0, 0, 1'b1, 1'b0);
        check_eq("drain", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
